// File: rtl/ac_pkg.sv
// Shared definitions for the AC control path: fan speed encodings, AC mode
// constants, fan driver FSM states and the speed-to-duty map.
package ac_pkg;

  localparam int unsigned FAN_SPEED_W = 3;

  localparam logic [FAN_SPEED_W-1:0] FAN_OFF = 3'd0;
  localparam logic [FAN_SPEED_W-1:0] FAN_S1  = 3'd1;
  localparam logic [FAN_SPEED_W-1:0] FAN_S2  = 3'd2;
  localparam logic [FAN_SPEED_W-1:0] FAN_S3  = 3'd3;
  localparam logic [FAN_SPEED_W-1:0] FAN_S4  = 3'd4;

  typedef enum logic [1:0] {
    AC_MODE_OFF,
    AC_MODE_COOL,
    AC_MODE_HEAT,
    AC_MODE_FAN
  } ac_mode_t;

  typedef enum logic [1:0] {
    FAN_IDLE,
    FAN_KICK,
    FAN_RAMP,
    FAN_HOLD
  } fan_state_t;

  // Commands above S4 saturate to full duty.
  function automatic logic [7:0] fan_speed_to_duty(input logic [FAN_SPEED_W-1:0] speed);
    logic [7:0] duty;
    case (speed)
      FAN_OFF: duty = 8'd0;
      FAN_S1:  duty = 8'd64;
      FAN_S2:  duty = 8'd128;
      FAN_S3:  duty = 8'd192;
      default: duty = 8'd255;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/fan_pwm_driver_pwm_gen.sv
// Free-running PWM counter and comparator with a registered output and a
// strobe marking the last cycle of each period.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm,
  output logic                o_boundary_c
);

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm;

  // Full-scale duty is forced high so the top code gives a solid drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      r_pwm <= (i_duty == '1) || (r_cnt < i_duty);
    end
  end

  assign o_boundary_c = (r_cnt == '1);
  assign o_pwm        = r_pwm;

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: maps the speed command to a duty target, applies a full-duty
// spin-up kick from rest and a rate-limited ramp between levels.
module fan_pwm_driver
  import ac_pkg::*;
#(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned RAMP_DIV     = 4,
  parameter int unsigned KICK_PERIODS = 2,
  parameter int unsigned DUTY_STEP    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          fan_speed,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty_current,
  output logic                ramping,
  output logic                fan_on
);

  localparam int unsigned DW = PWM_BITS + 1;
  localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] STEP      = DW'(DUTY_STEP);

  fan_state_t          r_state;
  logic [PWM_BITS-1:0] r_target;
  logic [PWM_BITS-1:0] r_duty;
  logic [KW-1:0]       r_kick_cnt;
  logic [RW-1:0]       r_ramp_cnt;
  logic                r_ramping;
  logic                r_fan_on;

  fan_state_t          w_state_nxt;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [KW-1:0]       w_kick_nxt;
  logic [RW-1:0]       w_ramp_nxt;
  logic [PWM_BITS-1:0] w_step_duty;
  logic [DW-1:0]       w_up_sum;
  logic [DW-1:0]       w_dn_diff;
  logic                w_boundary;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk          (clk),
    .reset        (reset),
    .i_duty       (r_duty),
    .o_pwm        (pwm_out),
    .o_boundary_c (w_boundary)
  );

  // One ramp step toward target, widened by a bit so it can neither wrap nor overshoot.
  always_comb begin
    w_up_sum    = {1'b0, r_duty} + STEP;
    w_dn_diff   = {1'b0, r_duty} - STEP;
    w_step_duty = r_duty;
    if (r_target > r_duty) begin
      w_step_duty = (w_up_sum > {1'b0, r_target}) ? r_target : w_up_sum[PWM_BITS-1:0];
    end else if (r_target < r_duty) begin
      w_step_duty = (w_dn_diff[PWM_BITS] || (w_dn_diff < {1'b0, r_target}))
                    ? r_target : w_dn_diff[PWM_BITS-1:0];
    end
  end

  // Next state; every transition is gated by the period boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_kick_nxt  = r_kick_cnt;
    w_ramp_nxt  = r_ramp_cnt;
    if (w_boundary) begin
      case (r_state)
        FAN_IDLE: begin
          if (r_target != '0) begin
            w_duty_nxt  = '1;
            w_kick_nxt  = '0;
            w_state_nxt = FAN_KICK;
          end
        end
        FAN_KICK: begin
          if (r_target == '0) begin
            w_duty_nxt  = '0;
            w_state_nxt = FAN_IDLE;
          end else if (r_kick_cnt == KICK_LAST) begin
            w_duty_nxt  = r_target;
            w_state_nxt = FAN_HOLD;
          end else begin
            w_kick_nxt = r_kick_cnt + KW'(1);
          end
        end
        FAN_HOLD: begin
          if (r_target != r_duty) begin
            w_ramp_nxt  = '0;
            w_state_nxt = FAN_RAMP;
          end
        end
        FAN_RAMP: begin
          if (r_ramp_cnt == RAMP_LAST) begin
            w_ramp_nxt = '0;
            w_duty_nxt = w_step_duty;
            if (w_step_duty == r_target) begin
              w_state_nxt = (r_target != '0) ? FAN_HOLD : FAN_IDLE;
            end
          end else begin
            w_ramp_nxt = r_ramp_cnt + RW'(1);
          end
        end
        default: w_state_nxt = FAN_IDLE;
      endcase
    end
  end

  // Status flags are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= FAN_IDLE;
      r_target   <= '0;
      r_duty     <= '0;
      r_kick_cnt <= '0;
      r_ramp_cnt <= '0;
      r_ramping  <= 1'b0;
      r_fan_on   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= PWM_BITS'(fan_speed_to_duty(fan_speed));
      r_duty     <= w_duty_nxt;
      r_kick_cnt <= w_kick_nxt;
      r_ramp_cnt <= w_ramp_nxt;
      r_ramping  <= (w_state_nxt == FAN_KICK) || (w_state_nxt == FAN_RAMP);
      r_fan_on   <= (w_state_nxt != FAN_IDLE);
    end
  end

  assign duty_current = r_duty;
  assign ramping      = r_ramping;
  assign fan_on       = r_fan_on;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver: kick, ramps up/down, mid-ramp reversal,
// IDLE return and asynchronous reset, with hand-computed duty sequences.
module tb_fan_pwm_driver;

  logic       clk;
  logic       reset;
  logic [2:0] fan_speed;
  logic       pwm_out;
  logic [7:0] duty_current;
  logic       ramping;
  logic       fan_on;

  logic [7:0] m_cnt;
  int         checks;
  int         failures;

  fan_pwm_driver dut (
    .clk          (clk),
    .reset        (reset),
    .fan_speed    (fan_speed),
    .pwm_out      (pwm_out),
    .duty_current (duty_current),
    .ramping      (ramping),
    .fan_on       (fan_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench copy of the free-running period counter, used only for alignment.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_cnt <= 8'd0;
    else        m_cnt <= m_cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((m_cnt != v) && (n < 600));
    if (n >= 600) chk("wait_timeout", 32'(m_cnt), 32'(v));
  endtask

  task automatic next_period();
    wait_cnt(8'd0);
  endtask

  // Count high cycles over the full period starting at the current boundary.
  task automatic measure(input string tag, input int exp_high);
    int high;
    wait_cnt(8'd1);
    high = int'(pwm_out);
    repeat (255) begin
      @(posedge clk);
      #1;
      high += int'(pwm_out);
    end
    chk(tag, 32'(high), 32'(exp_high));
  endtask

  task automatic enter_ramp(input string tag, input int prev);
    next_period();
    chk({tag, "_duty"}, 32'(duty_current), 32'(prev));
    chk({tag, "_ramping"}, 32'(ramping), 32'd1);
  endtask

  task automatic ramp_step(input string tag, input int prev, input int exp,
                           input bit last, input bit to_idle);
    repeat (3) next_period();
    chk({tag, "_mid_duty"}, 32'(duty_current), 32'(prev));
    chk({tag, "_mid_ramping"}, 32'(ramping), 32'd1);
    chk({tag, "_mid_fan_on"}, 32'(fan_on), 32'd1);
    next_period();
    chk({tag, "_duty"}, 32'(duty_current), 32'(exp));
    chk({tag, "_ramping"}, 32'(last ? 1'b0 : 1'b1), 32'(ramping));
    chk({tag, "_fan_on"}, 32'(fan_on), 32'((last && to_idle) ? 1'b0 : 1'b1));
  endtask

  int up_seq[8]    = '{144, 160, 176, 192, 208, 224, 240, 255};
  int dn3_seq[4]   = '{239, 223, 207, 192};
  int off_seq[12]  = '{176, 160, 144, 128, 112, 96, 80, 64, 48, 32, 16, 0};
  int rev_up[3]    = '{144, 160, 176};
  int rev_dn[7]    = '{160, 144, 128, 112, 96, 80, 64};

  initial begin
    int bad;
    int prev;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    fan_speed = 3'd0;

    @(posedge clk);
    #2;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_duty", 32'(duty_current), 32'd0);
    chk("rst_ramping", 32'(ramping), 32'd0);
    chk("rst_fan_on", 32'(fan_on), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Off command: nothing may move for 1000 cycles.
    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (pwm_out !== 1'b0 || fan_on !== 1'b0 || ramping !== 1'b0 || duty_current !== 8'd0)
        bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Spin-up from rest at speed 2.
    fan_speed = 3'd2;
    next_period();
    chk("kick1_duty", 32'(duty_current), 32'd255);
    chk("kick1_ramping", 32'(ramping), 32'd1);
    chk("kick1_fan_on", 32'(fan_on), 32'd1);
    measure("kick1_high", 256);
    chk("kick2_duty", 32'(duty_current), 32'd255);
    chk("kick2_ramping", 32'(ramping), 32'd1);
    next_period();
    chk("hold128_duty", 32'(duty_current), 32'd128);
    chk("hold128_ramping", 32'(ramping), 32'd0);
    chk("hold128_fan_on", 32'(fan_on), 32'd1);
    measure("hold128_high", 128);

    // 128 -> 255 in eight steps, last one saturating.
    fan_speed = 3'd4;
    enter_ramp("up_enter", 128);
    prev = 128;
    for (int i = 0; i < 8; i++) begin
      ramp_step("up", prev, up_seq[i], i == 7, 1'b0);
      prev = up_seq[i];
    end
    measure("hold255_high", 256);

    // 255 -> 192, clamps at target on the way down.
    fan_speed = 3'd3;
    enter_ramp("dn3_enter", 255);
    prev = 255;
    for (int i = 0; i < 4; i++) begin
      ramp_step("dn3", prev, dn3_seq[i], i == 3, 1'b0);
      prev = dn3_seq[i];
    end
    measure("hold192_high", 192);

    // 192 -> 0, then back to IDLE.
    fan_speed = 3'd0;
    enter_ramp("off_enter", 192);
    prev = 192;
    for (int i = 0; i < 12; i++) begin
      ramp_step("off", prev, off_seq[i], i == 11, 1'b1);
      prev = off_seq[i];
    end
    measure("idle_high", 0);
    chk("idle_stay_duty", 32'(duty_current), 32'd0);
    chk("idle_stay_fan_on", 32'(fan_on), 32'd0);

    // Re-kick, then a mid-ramp reversal with speed 7 then speed 1.
    fan_speed = 3'd2;
    next_period();
    chk("rekick_duty", 32'(duty_current), 32'd255);
    next_period();
    next_period();
    chk("rehold_duty", 32'(duty_current), 32'd128);
    fan_speed = 3'd7;
    enter_ramp("rev_enter", 128);
    prev = 128;
    for (int i = 0; i < 3; i++) begin
      ramp_step("rev_up", prev, rev_up[i], 1'b0, 1'b0);
      prev = rev_up[i];
    end
    fan_speed = 3'd1;
    for (int i = 0; i < 7; i++) begin
      ramp_step("rev_dn", prev, rev_dn[i], i == 6, 1'b0);
      prev = rev_dn[i];
    end
    measure("hold64_high", 64);

    // Asynchronous reset mid-ramp, between clock edges.
    fan_speed = 3'd4;
    enter_ramp("rst_enter", 64);
    ramp_step("rst_ramp", 64, 80, 1'b0, 1'b0);
    wait_cnt(8'd5);
    chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
    fan_speed = 3'd3;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'd0);
    chk("arst_duty", 32'(duty_current), 32'd0);
    chk("arst_ramping", 32'(ramping), 32'd0);
    chk("arst_fan_on", 32'(fan_on), 32'd0);
    #1;
    reset = 1'b1;
    next_period();
    chk("post_kick1_duty", 32'(duty_current), 32'd255);
    chk("post_kick1_ramping", 32'(ramping), 32'd1);
    next_period();
    chk("post_kick2_duty", 32'(duty_current), 32'd255);
    next_period();
    chk("post_hold_duty", 32'(duty_current), 32'd192);
    chk("post_hold_ramping", 32'(ramping), 32'd0);
    measure("post_hold_high", 192);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
